// File: rtl/ntt_bfly_pipe.sv
// ntt_bfly_pipe: four-stage modular butterfly for the NTT/INTT datapath.
//   mode 0 : Cooley-Tukey   a' = a + w*b,  b' = a - w*b            (mod q)
//   mode 1 : Gentleman-Sande a' = a + b,   b' = (a - b)*w          (mod q)
//            optionally both results multiplied by 2^-1 mod q (halve)
// The twiddle product uses Shoup multiplication with the precomputed wp.
// The modulus q, mode, halve and tag travel with every sample, so samples
// of different RNS channels and modes may follow each other back to back.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready = ~stall
//   in_a, in_b            operands in [0,q)
//   in_w, in_wp           twiddle and floor(w*2^DATA_W/q)
//   in_q                  odd modulus, 3 <= q < 2^(DATA_W-1)
//   in_mode, in_halve     0 = CT, 1 = GS; halve only acts in GS mode
//   in_tag                sideband returned unchanged on out_tag
//   out_valid / out_ready output handshake; outputs hold while stalled
//   out_a, out_b, out_tag results in [0,q) and the sample's tag
//   busy                  any pipeline stage holds a valid sample
module ntt_bfly_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_w,
  input  logic [DATA_W-1:0] in_wp,
  input  logic [DATA_W-1:0] in_q,
  input  logic              in_mode,
  input  logic              in_halve,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  // Per-sample control that rides alongside the data through every stage.
  typedef struct packed {
    logic              mode;
    logic              halve;
    logic [DATA_W-1:0] q;
    logic [TAG_W-1:0]  tag;
  } side_t;

  // x/2 mod q for odd q: add q first when x is odd so the shift is exact.
  function automatic logic [DATA_W-1:0] halve_mod(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] q);
    logic [DATA_W:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    return t[DATA_W:1];
  endfunction

  logic stall;

  // Stage registers
  logic              s1_valid, s2_valid, s3_valid;
  logic [DATA_W-1:0] s1_a, s1_b, s1_w, s1_wp;
  side_t             s1_side, s2_side, s3_side;
  logic [DATA_W-1:0] s2_x, s2_p, s2_h;   // x = a (CT) or s = a+b mod q (GS)
  logic [DATA_W-1:0] s3_x, s3_r;         // r = m*w mod q

  // Combinational stage logic
  logic [DATA_W:0]     c2_sum, c2_sub;
  logic [DATA_W-1:0]   c2_s, c2_d, c2_m, c2_x;
  logic [2*DATA_W-1:0] c2_pw, c2_hw;
  logic [2*DATA_W-1:0] c3_hq;
  logic [DATA_W-1:0]   c3_raw, c3_r;
  logic [DATA_W:0]     c4_sum, c4_sub;
  logic [DATA_W-1:0]   c4_ct_a, c4_ct_b, c4_a, c4_b;
  logic                c4_do_halve;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign busy     = s1_valid | s2_valid | s3_valid | out_valid;

  // NOTE: every combinational output is assigned on every pass through the
  // block, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    // S2: pre-add/sub for GS, then the two Shoup partial products.
    c2_sum = {1'b0, s1_a} + {1'b0, s1_b};
    c2_sub = c2_sum - {1'b0, s1_side.q};
    c2_s   = (c2_sum >= {1'b0, s1_side.q}) ? c2_sub[DATA_W-1:0] : c2_sum[DATA_W-1:0];
    c2_d   = (s1_a < s1_b) ? (s1_a - s1_b + s1_side.q) : (s1_a - s1_b);
    c2_m   = s1_side.mode ? c2_d : s1_b;
    c2_x   = s1_side.mode ? c2_s : s1_a;
    c2_pw  = {{DATA_W{1'b0}}, c2_m} * {{DATA_W{1'b0}}, s1_w};
    c2_hw  = {{DATA_W{1'b0}}, c2_m} * {{DATA_W{1'b0}}, s1_wp};

    // S3: Shoup remainder lands in [0,2q) modulo 2^DATA_W; one correction.
    c3_hq  = {{DATA_W{1'b0}}, s2_h} * {{DATA_W{1'b0}}, s2_side.q};
    c3_raw = s2_p - c3_hq[DATA_W-1:0];
    c3_r   = (c3_raw >= s2_side.q) ? (c3_raw - s2_side.q) : c3_raw;

    // S4: CT add/sub, or GS pass-through, then optional halving.
    c4_sum  = {1'b0, s3_x} + {1'b0, s3_r};
    c4_sub  = c4_sum - {1'b0, s3_side.q};
    c4_ct_a = (c4_sum >= {1'b0, s3_side.q}) ? c4_sub[DATA_W-1:0] : c4_sum[DATA_W-1:0];
    c4_ct_b = (s3_x < s3_r) ? (s3_x - s3_r + s3_side.q) : (s3_x - s3_r);
    c4_a    = s3_side.mode ? s3_x : c4_ct_a;
    c4_b    = s3_side.mode ? s3_r : c4_ct_b;
    c4_do_halve = s3_side.mode & s3_side.halve;
    if (c4_do_halve) begin
      c4_a = halve_mod(c4_a, s3_side.q);
      c4_b = halve_mod(c4_b, s3_side.q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: datapath registers are reset as well as the valid bits, so the
      // outputs read as zero under reset rather than leftover data.
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_w      <= '0;
      s1_wp     <= '0;
      s1_side   <= '0;
      s2_valid  <= 1'b0;
      s2_x      <= '0;
      s2_p      <= '0;
      s2_h      <= '0;
      s2_side   <= '0;
      s3_valid  <= 1'b0;
      s3_x      <= '0;
      s3_r      <= '0;
      s3_side   <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      // Whole pipe advances together; bubbles move along like samples.
      s1_valid      <= in_valid;
      s1_a          <= in_a;
      s1_b          <= in_b;
      s1_w          <= in_w;
      s1_wp         <= in_wp;
      s1_side.mode  <= in_mode;
      s1_side.halve <= in_halve;
      s1_side.q     <= in_q;
      s1_side.tag   <= in_tag;

      s2_valid <= s1_valid;
      s2_x     <= c2_x;
      s2_p     <= c2_pw[DATA_W-1:0];
      s2_h     <= c2_hw[2*DATA_W-1:DATA_W];
      s2_side  <= s1_side;

      s3_valid <= s2_valid;
      s3_x     <= s2_x;
      s3_r     <= c3_r;
      s3_side  <= s2_side;

      out_valid <= s3_valid;
      out_a     <= c4_a;
      out_b     <= c4_b;
      out_tag   <= s3_side.tag;
    end
  end

endmodule
